// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the write-back stage and the fetch stage.
//   WB_*        bit indices into the memory-stage write-back control word
//   exc_state_t exception-sequencer state encoding
//   exc_cause_t exception cause encoding (0 = no exception)
//   VEC_*_ADDR  exception vector addresses
package cpu_pkg;
   localparam int WB_REGWRITE = 0;
   localparam int WB_MEMTOREG = 1;
   typedef logic [1:0] exc_state_t;
   localparam exc_state_t IDLE       = 2'd0;
   localparam exc_state_t EXC_FLUSH  = 2'd1;
   localparam exc_state_t EXC_VECTOR = 2'd2;
   typedef logic [1:0] exc_cause_t;
   localparam exc_cause_t EXC_NONE   = 2'b00;
   localparam exc_cause_t EXC_CAUSE0 = 2'b01;
   localparam exc_cause_t EXC_CAUSE1 = 2'b10;
   localparam exc_cause_t EXC_CAUSE2 = 2'b11;
   localparam logic [31:0] VEC_EXC0_ADDR = 32'h0000_0002;
   localparam logic [31:0] VEC_EXC1_ADDR = 32'h0000_0004;
   // Cause 01 has its own vector; both remaining causes share the second one.
   function automatic logic [31:0] exc_vector(input exc_cause_t c, input logic [31:0] v0, input logic [31:0] v1);
      return (c == EXC_CAUSE0) ? v0 : v1;
   endfunction
endpackage

// File: rtl/wb_exc_fsm.sv
// wb_exc_fsm: exception sequencer with EPC and cause capture.
//   clk, i_reset  clock, synchronous active-high reset
//   i_changeEPC   exception cause from the memory stage (0 = none)
//   i_pc          PC of the instruction in the memory stage
//   o_idle        sequencer is idle (no exception in progress)
//   o_flushPipe   flush request, high in EXC_FLUSH and EXC_VECTOR
//   o_vector      vector redirect strobe (EXC_VECTOR)
//   o_vectorPc    vector target for the latched cause
//   o_epc         captured exception PC
//   o_excCause    captured exception cause
module wb_exc_fsm
   import cpu_pkg::*;
#(
   parameter logic [31:0] VEC_EXC0 = VEC_EXC0_ADDR,
   parameter logic [31:0] VEC_EXC1 = VEC_EXC1_ADDR
) (
   input  logic        clk,
   input  logic        i_reset,
   input  logic [1:0]  i_changeEPC,
   input  logic [31:0] i_pc,
   output logic        o_idle,
   output logic        o_flushPipe,
   output logic        o_vector,
   output logic [31:0] o_vectorPc,
   output logic [31:0] o_epc,
   output logic [1:0]  o_excCause
);
   exc_state_t  state_q, state_d;
   logic [31:0] epc_q, epc_d;
   exc_cause_t  cause_q, cause_d;
   logic        capture;
   // A new cause is only accepted from IDLE; later ones are dropped so the
   // first EPC/cause survive until the handler has been vectored.
   always_comb begin
      capture = (state_q == IDLE) && (i_changeEPC != EXC_NONE);
      state_d = capture ? EXC_FLUSH : (state_q == EXC_FLUSH) ? EXC_VECTOR : IDLE;
      epc_d   = capture ? i_pc : epc_q;
      cause_d = capture ? i_changeEPC : cause_q;
   end
   always_ff @(posedge clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         epc_q   <= '0;
         cause_q <= EXC_NONE;
      end else begin
         state_q <= state_d;
         epc_q   <= epc_d;
         cause_q <= cause_d;
      end
   end
   assign o_idle      = state_q == IDLE;
   assign o_flushPipe = (state_q == EXC_FLUSH) || (state_q == EXC_VECTOR);
   assign o_vector    = state_q == EXC_VECTOR;
   assign o_vectorPc  = o_vector ? exc_vector(cause_q, VEC_EXC0, VEC_EXC1) : '0;
   assign o_epc       = epc_q;
   assign o_excCause  = cause_q;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage; MEM/WB register, register-file write port,
// RET/RTI redirect decode and exception sequencing.
//   clk, i_reset            clock, synchronous active-high reset
//   i_stall, i_flush        hold / bubble the MEM/WB register
//   i_wb, i_rdst            write-back control and destination
//   i_aluData, i_memData    ALU result and memory word
//   i_isRet, i_isRti        instruction pops a return word
//   i_pc, i_changeEPC       faulting PC and exception cause
//   o_regWrite/o_rdst/o_wbData      register-file write port
//   o_redirect/o_redirectPc         one-cycle PC redirect
//   o_flagsLoad/o_flags             one-cycle flag restore (RTI)
//   o_flushPipe, o_epc, o_excCause  exception outputs
module wb_stage
   import cpu_pkg::*;
#(
   parameter int          REG_ADDR_W = 3,
   parameter logic [31:0] VEC_EXC0   = VEC_EXC0_ADDR,
   parameter logic [31:0] VEC_EXC1   = VEC_EXC1_ADDR
) (
   input  logic                  clk,
   input  logic                  i_reset,
   input  logic                  i_stall,
   input  logic                  i_flush,
   input  logic [1:0]            i_wb,
   input  logic [REG_ADDR_W-1:0] i_rdst,
   input  logic [15:0]           i_aluData,
   input  logic [31:0]           i_memData,
   input  logic                  i_isRet,
   input  logic                  i_isRti,
   input  logic [31:0]           i_pc,
   input  logic [1:0]            i_changeEPC,
   output logic                  o_regWrite,
   output logic [REG_ADDR_W-1:0] o_rdst,
   output logic [15:0]           o_wbData,
   output logic                  o_redirect,
   output logic [31:0]           o_redirectPc,
   output logic                  o_flagsLoad,
   output logic [3:0]            o_flags,
   output logic                  o_flushPipe,
   output logic [31:0]           o_epc,
   output logic [1:0]            o_excCause
);
   logic [1:0]            wb_q, wb_d;
   logic [REG_ADDR_W-1:0] rdst_q, rdst_d;
   logic [15:0]           alu_q, alu_d;
   logic [31:0]           mem_q, mem_d;
   logic                  ret_q, ret_d, rti_q, rti_d;
   logic                  fresh_q, fresh_d;
   logic                  exc_idle, exc_vector_s, kill, keep, ret_fire;
   logic [31:0]           exc_pc;
   wb_exc_fsm #(.VEC_EXC0(VEC_EXC0), .VEC_EXC1(VEC_EXC1)) u_exc (
      .clk(clk),
      .i_reset(i_reset),
      .i_changeEPC(i_changeEPC),
      .i_pc(i_pc),
      .o_idle(exc_idle),
      .o_flushPipe(o_flushPipe),
      .o_vector(exc_vector_s),
      .o_vectorPc(exc_pc),
      .o_epc(o_epc),
      .o_excCause(o_excCause)
   );
   // Exception bubbles outrank flush, which outranks stall. fresh_q marks the
   // first cycle an instruction sits in the register so a stalled RET/RTI
   // strobes only once.
   always_comb begin
      kill    = !exc_idle || (i_changeEPC != EXC_NONE) || i_flush;
      keep    = !kill && i_stall;
      wb_d    = kill ? 2'b00 : keep ? wb_q : i_wb;
      ret_d   = kill ? 1'b0 : keep ? ret_q : i_isRet;
      rti_d   = kill ? 1'b0 : keep ? rti_q : i_isRti;
      rdst_d  = keep ? rdst_q : i_rdst;
      alu_d   = keep ? alu_q : i_aluData;
      mem_d   = keep ? mem_q : i_memData;
      fresh_d = !keep;
   end
   always_ff @(posedge clk) begin
      if (i_reset) begin
         wb_q    <= '0;
         rdst_q  <= '0;
         alu_q   <= '0;
         mem_q   <= '0;
         ret_q   <= 1'b0;
         rti_q   <= 1'b0;
         fresh_q <= 1'b0;
      end else begin
         wb_q    <= wb_d;
         rdst_q  <= rdst_d;
         alu_q   <= alu_d;
         mem_q   <= mem_d;
         ret_q   <= ret_d;
         rti_q   <= rti_d;
         fresh_q <= fresh_d;
      end
   end
   assign ret_fire     = (ret_q || rti_q) && fresh_q && exc_idle;
   assign o_regWrite   = wb_q[WB_REGWRITE];
   assign o_rdst       = rdst_q;
   assign o_wbData     = wb_q[WB_MEMTOREG] ? mem_q[15:0] : alu_q;
   assign o_redirect   = exc_vector_s || ret_fire;
   assign o_redirectPc = exc_vector_s ? exc_pc : {4'b0, mem_q[27:0]};
   assign o_flagsLoad  = rti_q && fresh_q && exc_idle;
   assign o_flags      = mem_q[31:28];
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage.
module tb_wb_stage;
   typedef struct packed {
      logic        rw;
      logic [2:0]  rd;
      logic [15:0] wbd;
      logic        redir;
      logic [31:0] rpc;
      logic        fl;
      logic [3:0]  flags;
      logic        fp;
      logic [31:0] epc;
      logic [1:0]  cause;
   } out_t;

   logic        clk = 1'b0;
   logic        i_reset, i_stall, i_flush, i_isRet, i_isRti;
   logic [1:0]  i_wb, i_changeEPC;
   logic [2:0]  i_rdst;
   logic [15:0] i_aluData;
   logic [31:0] i_memData, i_pc;
   logic        o_regWrite, o_redirect, o_flagsLoad, o_flushPipe;
   logic [2:0]  o_rdst;
   logic [15:0] o_wbData;
   logic [31:0] o_redirectPc, o_epc;
   logic [3:0]  o_flags;
   logic [1:0]  o_excCause;
   out_t        obs, e, g;
   out_t        sb[$];
   int          checks = 0;
   int          errors = 0;

   wb_stage dut (
      .clk(clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush),
      .i_wb(i_wb), .i_rdst(i_rdst), .i_aluData(i_aluData), .i_memData(i_memData),
      .i_isRet(i_isRet), .i_isRti(i_isRti), .i_pc(i_pc), .i_changeEPC(i_changeEPC),
      .o_regWrite(o_regWrite), .o_rdst(o_rdst), .o_wbData(o_wbData),
      .o_redirect(o_redirect), .o_redirectPc(o_redirectPc),
      .o_flagsLoad(o_flagsLoad), .o_flags(o_flags), .o_flushPipe(o_flushPipe),
      .o_epc(o_epc), .o_excCause(o_excCause)
   );

   always #5 clk = ~clk;

   assign obs = {o_regWrite, o_rdst, o_wbData, o_redirect, o_redirectPc,
                 o_flagsLoad, o_flags, o_flushPipe, o_epc, o_excCause};

   function automatic out_t mk(input logic rw, input logic [2:0] rd, input logic [15:0] wbd,
                               input logic redir, input logic [31:0] rpc, input logic fl,
                               input logic [3:0] flags, input logic fp, input logic [31:0] epc,
                               input logic [1:0] cause);
      out_t r;
      r = '{rw, rd, wbd, redir, rpc, fl, flags, fp, epc, cause};
      return r;
   endfunction

   // Fields whose value is only meaningful under their strobe are blanked.
   function automatic out_t norm(input out_t o, input out_t x);
      out_t r;
      r = o;
      if (!x.rw) begin
         r.rd  = '0;
         r.wbd = '0;
      end
      if (!x.redir) r.rpc = '0;
      if (!x.fl) r.flags = '0;
      return r;
   endfunction

   task automatic drive(input logic rst, input logic stall, input logic flush, input logic [1:0] wb,
                        input logic [2:0] rd, input logic [15:0] alu, input logic [31:0] mem,
                        input logic ret, input logic rti, input logic [31:0] pc, input logic [1:0] cause);
      i_reset = rst; i_stall = stall; i_flush = flush; i_wb = wb; i_rdst = rd;
      i_aluData = alu; i_memData = mem; i_isRet = ret; i_isRti = rti; i_pc = pc; i_changeEPC = cause;
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 2'b11, 3'd7, 16'hFFFF, 32'hFFFF_FFFF, 1, 1, 32'h55, 2'b01);
      sb.push_back('0);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset: got %h expected %h", obs, e); end
      drive(0, 0, 0, 2'b00, 3'd0, 16'h0, 32'h0, 0, 0, 32'h0, 2'b00);
      sb.push_back('0);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_release: got %h expected %h", obs, e); end
   endtask

   task automatic test_alu_wb();
      drive(0, 0, 0, 2'b01, 3'd3, 16'h1234, 32'h0, 0, 0, 32'h0, 2'b00);
      sb.push_back(mk(1, 3'd3, 16'h1234, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      e = sb.pop_front(); g = norm(obs, e);
      checks++;
      if (g !== e) begin errors++; $display("FAIL alu_wb: got %h expected %h", g, e); end
      drive(0, 0, 0, 2'b00, 3'd6, 16'hBEEF, 32'h0, 0, 0, 32'h0, 2'b00);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      e = sb.pop_front(); g = norm(obs, e);
      checks++;
      if (g !== e) begin errors++; $display("FAIL no_write: got %h expected %h", g, e); end
   endtask

   task automatic test_load_stall_flush();
      drive(0, 0, 0, 2'b11, 3'd5, 16'h1111, 32'hABCD_5678, 0, 0, 32'h0, 2'b00);
      sb.push_back(mk(1, 3'd5, 16'h5678, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      e = sb.pop_front(); g = norm(obs, e);
      checks++;
      if (g !== e) begin errors++; $display("FAIL load_wb: got %h expected %h", g, e); end
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 2'b01, 3'd2, 16'h9999, 32'h0, 0, 0, 32'h0, 2'b00);
         sb.push_back(mk(1, 3'd5, 16'h5678, 0, 0, 0, 0, 0, 0, 0));
         @(negedge clk);
         e = sb.pop_front(); g = norm(obs, e);
         checks++;
         if (g !== e) begin errors++; $display("FAIL stall_hold%0d: got %h expected %h", i, g, e); end
      end
      drive(0, 1, 1, 2'b01, 3'd2, 16'h9999, 32'h0, 0, 0, 32'h0, 2'b00);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      e = sb.pop_front(); g = norm(obs, e);
      checks++;
      if (g !== e) begin errors++; $display("FAIL flush_over_stall: got %h expected %h", g, e); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] d;
      for (int i = 0; i < 6; i++) begin
         d = 16'(i * 16'h1357 + 16'h0101);
         drive(0, 0, 0, {i[0], 1'b1}, 3'(i + 1), d, {16'hDEAD, ~d}, 0, 0, 32'h0, 2'b00);
         sb.push_back(mk(1, 3'(i + 1), i[0] ? ~d : d, 0, 0, 0, 0, 0, 0, 0));
         @(negedge clk);
         e = sb.pop_front(); g = norm(obs, e);
         checks++;
         if (g !== e) begin errors++; $display("FAIL b2b%0d: got %h expected %h", i, g, e); end
      end
   endtask

   task automatic test_ret_rti();
      drive(0, 0, 0, 2'b00, 3'd0, 16'h0, 32'hA000_0011, 0, 1, 32'h0, 2'b00);
      sb.push_back(mk(0, 0, 0, 1, 32'h11, 1, 4'hA, 0, 0, 0));
      drive(0, 0, 0, 2'b00, 3'd0, 16'h0, 32'hA000_0011, 0, 1, 32'h0, 2'b00);
      @(negedge clk);
      e = sb.pop_front(); g = norm(obs, e);
      checks++;
      if (g !== e) begin errors++; $display("FAIL rti: got %h expected %h", g, e); end
      drive(0, 0, 0, 2'b00, 3'd0, 16'h0, 32'hA000_0011, 1, 0, 32'h0, 2'b00);
      sb.push_back(mk(0, 0, 0, 1, 32'h11, 0, 0, 0, 0, 0));
      @(negedge clk);
      e = sb.pop_front(); g = norm(obs, e);
      checks++;
      if (g !== e) begin errors++; $display("FAIL ret: got %h expected %h", g, e); end
      drive(0, 0, 0, 2'b00, 3'd0, 16'h0, 32'h5000_0020, 0, 1, 32'h0, 2'b00);
      sb.push_back(mk(0, 0, 0, 1, 32'h20, 1, 4'h5, 0, 0, 0));
      @(negedge clk);
      e = sb.pop_front(); g = norm(obs, e);
      checks++;
      if (g !== e) begin errors++; $display("FAIL rti_stall_first: got %h expected %h", g, e); end
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 0, 2'b00, 3'd0, 16'h0, 32'h0, 0, 0, 32'h0, 2'b00);
         sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         @(negedge clk);
         e = sb.pop_front(); g = norm(obs, e);
         checks++;
         if (g !== e) begin errors++; $display("FAIL rti_stall_once%0d: got %h expected %h", i, g, e); end
      end
      drive(0, 0, 0, 2'b00, 3'd0, 16'h0, 32'h0, 0, 0, 32'h0, 2'b00);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      e = sb.pop_front(); g = norm(obs, e);
      checks++;
      if (g !== e) begin errors++; $display("FAIL ret_idle: got %h expected %h", g, e); end
   endtask

   task automatic test_exception(input logic [1:0] cause, input logic [31:0] pc, input logic [31:0] vec);
      drive(0, 0, 0, 2'b01, 3'd4, 16'h5555, 32'h0, 0, 0, pc, cause);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, pc, cause));
      @(negedge clk);
      e = sb.pop_front(); g = norm(obs, e);
      checks++;
      if (g !== e) begin errors++; $display("FAIL exc_flush_c%0d: got %h expected %h", cause, g, e); end
      drive(0, 0, 0, 2'b01, 3'd4, 16'h5555, 32'h0, 0, 0, 32'h0, 2'b00);
      sb.push_back(mk(0, 0, 0, 1, vec, 0, 0, 1, pc, cause));
      @(negedge clk);
      e = sb.pop_front(); g = norm(obs, e);
      checks++;
      if (g !== e) begin errors++; $display("FAIL exc_vector_c%0d: got %h expected %h", cause, g, e); end
      drive(0, 0, 0, 2'b00, 3'd0, 16'h0, 32'h0, 0, 0, 32'h0, 2'b00);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, pc, cause));
      @(negedge clk);
      e = sb.pop_front(); g = norm(obs, e);
      checks++;
      if (g !== e) begin errors++; $display("FAIL exc_done_c%0d: got %h expected %h", cause, g, e); end
   endtask

   task automatic test_overlap();
      drive(0, 0, 0, 2'b00, 3'd0, 16'h0, 32'h0, 0, 0, 32'h100, 2'b01);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 2'b01));
      @(negedge clk);
      e = sb.pop_front(); g = norm(obs, e);
      checks++;
      if (g !== e) begin errors++; $display("FAIL ovl_flush: got %h expected %h", g, e); end
      drive(0, 1, 0, 2'b01, 3'd1, 16'h7777, 32'h9000_0033, 0, 1, 32'h200, 2'b10);
      sb.push_back(mk(0, 0, 0, 1, 32'h2, 0, 0, 1, 32'h100, 2'b01));
      @(negedge clk);
      e = sb.pop_front(); g = norm(obs, e);
      checks++;
      if (g !== e) begin errors++; $display("FAIL ovl_vector: got %h expected %h", g, e); end
      drive(0, 1, 0, 2'b00, 3'd0, 16'h0, 32'h9000_0033, 1, 0, 32'h300, 2'b11);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 2'b01));
      @(negedge clk);
      e = sb.pop_front(); g = norm(obs, e);
      checks++;
      if (g !== e) begin errors++; $display("FAIL ovl_ignored_cause: got %h expected %h", g, e); end
      drive(0, 0, 0, 2'b00, 3'd0, 16'h0, 32'h0000_0044, 1, 0, 32'h0, 2'b00);
      sb.push_back(mk(0, 0, 0, 1, 32'h44, 0, 0, 0, 32'h100, 2'b01));
      @(negedge clk);
      e = sb.pop_front(); g = norm(obs, e);
      checks++;
      if (g !== e) begin errors++; $display("FAIL ovl_ret_after: got %h expected %h", g, e); end
   endtask

   task automatic test_reset_mid();
      drive(0, 0, 0, 2'b00, 3'd0, 16'h0, 32'h0, 0, 0, 32'h300, 2'b10);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h300, 2'b10));
      @(negedge clk);
      e = sb.pop_front(); g = norm(obs, e);
      checks++;
      if (g !== e) begin errors++; $display("FAIL rstmid_flush: got %h expected %h", g, e); end
      drive(1, 0, 0, 2'b00, 3'd0, 16'h0, 32'h0, 0, 0, 32'h0, 2'b00);
      sb.push_back('0);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL rstmid_reset: got %h expected %h", obs, e); end
      drive(0, 0, 0, 2'b00, 3'd0, 16'h0, 32'h0, 0, 0, 32'h0, 2'b00);
      sb.push_back('0);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL rstmid_no_redirect: got %h expected %h", obs, e); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_alu_wb();
      test_load_stall_flush();
      test_back_to_back();
      test_ret_rti();
      test_exception(2'b01, 32'h40, 32'h2);
      test_exception(2'b10, 32'h80, 32'h4);
      test_exception(2'b11, 32'hC0, 32'h4);
      test_overlap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Write-back stage directly downstream of the memory stage; consumes its write-back control, ALU data and memory data.
- Holds the MEM/WB pipeline register with stall and flush control.
- Selects and drives the register-file write port.
- Decodes popped return words (RET/RTI) into a PC redirect and a flag restore.
- Sequences exception handling (EPC capture, pipeline flush, vector redirect) through a small FSM.

Parameters:
REG_ADDR_W, 3, register-file address width
VEC_EXC0, 32'h0000_0002, redirect target for exception cause 2'b01
VEC_EXC1, 32'h0000_0004, redirect target for exception cause 2'b10 or 2'b11

Ports:
clk  in  1  clock, rising edge
i_reset  in  1  reset, synchronous, active-high
i_stall  in  1  hold MEM/WB register contents
i_flush  in  1  insert bubble into MEM/WB register
i_wb  in  2  [0]=regWrite, [1]=memToReg (memory stage o_wb)
i_rdst  in  REG_ADDR_W  destination register
i_aluData  in  16  memory stage o_aluData
i_memData  in  32  memory stage o_memData
i_isRet  in  1  instruction is RET (pops return word)
i_isRti  in  1  instruction is RTI (pops return word plus flags)
i_pc  in  32  PC of the instruction in the memory stage
i_changeEPC  in  2  exception cause from the memory stage, 0 = none
o_regWrite  out  1  register-file write enable
o_rdst  out  REG_ADDR_W  register-file write address
o_wbData  out  16  register-file write data
o_redirect  out  1  one-cycle PC redirect strobe
o_redirectPc  out  32  redirect target
o_flagsLoad  out  1  one-cycle flag-restore strobe
o_flags  out  4  restored flags
o_flushPipe  out  1  flush request to all earlier stages
o_epc  out  32  exception PC
o_excCause  out  2  latched exception cause

Behaviour:
- Reset: every MEM/WB register field = 0, FSM = IDLE, o_epc = 0, o_excCause = 0. All outputs read 0 in the cycle after reset is sampled.
- MEM/WB register update priority: i_reset > exception-bubble (FSM not IDLE, or i_changeEPC != 0) > i_flush > i_stall > load.
  - Bubble: regWrite = 0, isRet = 0, isRti = 0; data fields don't-care.
  - Stall: all fields hold.
- Latency: inputs sampled at edge N drive outputs during cycle N+1. No combinational path from any input to any output.
- Write port:
  - o_regWrite = reg.wb[0]; o_rdst = reg.rdst.
  - o_wbData = reg.wb[1] ? reg.memData[15:0] : reg.aluData.
- Return decode (memory stage pushes (pc+1) | {flags, 28'd0}):
  - RET or RTI held in the register → o_redirect = 1, o_redirectPc = {4'b0, reg.memData[27:0]}.
  - RTI additionally → o_flagsLoad = 1, o_flags = reg.memData[31:28].
  - Strobes assert for exactly one cycle per instruction, including under stall: a stalled RET fires once, on its first cycle in the register.
- Exception FSM:
  - IDLE → EXC_FLUSH when i_changeEPC != 0 and not i_reset. At that edge: o_epc <= i_pc, o_excCause <= i_changeEPC. The faulting instruction is bubbled.
  - EXC_FLUSH (1 cycle): o_flushPipe = 1; go to EXC_VECTOR.
  - EXC_VECTOR (1 cycle): o_flushPipe = 1, o_redirect = 1, o_redirectPc = (cause == 2'b01) ? VEC_EXC0 : VEC_EXC1; go to IDLE.
  - i_changeEPC != 0 while not IDLE: ignored. EPC and cause are not overwritten.
- Simultaneous events:
  - Exception redirect outranks a RET/RTI redirect in the same cycle.
  - RET/RTI strobes are suppressed while the FSM is not IDLE.
  - i_stall does not freeze the FSM.
- Reset mid-operation: FSM returns to IDLE, pending redirect is dropped, o_epc cleared.
- All arithmetic is zero-extended; no sign extension anywhere.

Decomposition:
- Shared package (cpu_pkg):
  - WB bit indices: WB_REGWRITE = 0, WB_MEMTOREG = 1.
  - FSM state typedef: IDLE, EXC_FLUSH, EXC_VECTOR.
  - Exception cause encodings.
  - Vector address constants, also used by the fetch stage.
- One sub-module, wb_exc_fsm: exception FSM plus EPC/cause registers. The write-back register and muxing stay in wb_stage.

Test Plan:
- ALU write-back: i_wb = 2'b01, i_rdst = 3, i_aluData = 16'h1234 → next cycle o_regWrite = 1, o_rdst = 3, o_wbData = 16'h1234.
- Load write-back: i_wb = 2'b11, i_memData = 32'hABCD_5678 → o_wbData = 16'h5678. Then i_stall = 1 for 3 cycles → outputs hold; i_flush = 1 → o_regWrite = 0.
- RTI: i_isRti = 1, i_memData = 32'hA000_0011 → one cycle of o_redirect = 1, o_redirectPc = 32'h11, o_flagsLoad = 1, o_flags = 4'hA. RET with the same data → o_flagsLoad stays 0.
- Exception: i_changeEPC = 2'b01, i_pc = 32'h40 → o_epc = 32'h40; o_flushPipe high 2 cycles; o_redirectPc = 32'h2 in the second cycle. Repeat with cause 2'b10 → target 32'h4.
- Overlap: second i_changeEPC = 2'b10 during EXC_FLUSH → o_epc and o_excCause unchanged. RET present during EXC_VECTOR → o_redirectPc = vector.
- Reset during EXC_FLUSH: i_reset = 1 → next cycle o_flushPipe = 0, o_redirect = 0, o_epc = 0, all outputs 0.
